// File: rtl/grid_mem_arb.sv
// rtl/grid_mem_arb.sv - single-port grid RAM arbiter: VGA render > clear sweep > game engine
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   vga_req/vga_gx/vga_gy            render read request (every cycle of de)
//   vga_rdata/vga_rvalid             render read data, 2 cycles after request
//   game_valid/game_ready/game_we    game request handshake, write select
//   game_gx/game_gy/game_wdata       game coordinate and write data
//   game_rdata/game_rvalid           game read data, 2 cycles after accept
//   clr_start/clr_value/clr_busy     clear sweep control and status
//   mem_en/mem_we/mem_addr/mem_wdata RAM port, combinational from the grant
//   mem_rdata                        RAM read data, 1 cycle after mem_en
module grid_mem_arb #(
    parameter int GRID_COLS = 80,
    parameter int GRID_ROWS = 60,
    parameter int CELL_W    = 2,
    parameter int ADDR_W    = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [7:0]        vga_gx,
    input  logic [6:0]        vga_gy,
    output logic [CELL_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              game_valid,
    output logic              game_ready,
    input  logic              game_we,
    input  logic [7:0]        game_gx,
    input  logic [6:0]        game_gy,
    input  logic [CELL_W-1:0] game_wdata,
    output logic [CELL_W-1:0] game_rdata,
    output logic              game_rvalid,
    input  logic              clr_start,
    input  logic [CELL_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CELL_W-1:0] mem_wdata,
    input  logic [CELL_W-1:0] mem_rdata
);

    localparam int CELLS = GRID_COLS * GRID_ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } clr_state_e;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] gx, input logic [6:0] gy);
        return ADDR_W'(gy) * ADDR_W'(GRID_COLS) + ADDR_W'(gx);
    endfunction

    function automatic logic in_range(input logic [7:0] gx, input logic [6:0] gy);
        return (32'(gx) < GRID_COLS) && (32'(gy) < GRID_ROWS);
    endfunction

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [CELL_W-1:0] clr_val_q, clr_val_d;

    // Stage 1: a read was issued last cycle (RAM data is on mem_rdata now).
    logic vga_p1_q, vga_p1_d;
    logic vga_oor_p1_q, vga_oor_p1_d;
    logic game_p1_q, game_p1_d;
    logic game_oor_p1_q, game_oor_p1_d;

    // Stage 2: registered read data presented to the users.
    logic              vga_rvalid_q, vga_rvalid_d;
    logic [CELL_W-1:0] vga_rdata_q, vga_rdata_d;
    logic              game_rvalid_q, game_rvalid_d;
    logic [CELL_W-1:0] game_rdata_q, game_rdata_d;

    logic vga_in, game_in, clr_grant, game_acc;

    assign clr_busy    = (state_q == S_SWEEP);
    assign vga_in      = in_range(vga_gx, vga_gy);
    assign game_in     = in_range(game_gx, game_gy);
    assign clr_grant   = clr_busy & ~vga_req;
    // clr_start also blocks the game so the sweep never races a same-cycle write.
    assign game_ready  = rst_n & ~vga_req & ~clr_busy & ~clr_start;
    assign game_acc    = game_valid & game_ready;

    assign vga_rdata   = vga_rdata_q;
    assign vga_rvalid  = vga_rvalid_q;
    assign game_rdata  = game_rdata_q;
    assign game_rvalid = game_rvalid_q;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (vga_req) begin
            if (vga_in) begin
                mem_en   = 1'b1;
                mem_addr = cell_addr(vga_gx, vga_gy);
            end
        end else if (clr_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_q;
            mem_wdata = clr_val_q;
        end else if (game_acc && game_in) begin
            mem_en    = 1'b1;
            mem_we    = game_we;
            mem_addr  = cell_addr(game_gx, game_gy);
            mem_wdata = game_we ? game_wdata : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_val_d = clr_val_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d   = S_SWEEP;
                    clr_cnt_d = '0;
                    clr_val_d = clr_value;
                end
            end
            S_SWEEP: begin
                // A VGA-stolen cycle writes nothing, so the counter stalls.
                if (!vga_req) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d   = S_IDLE;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vga_p1_d      = vga_req;
        vga_oor_p1_d  = ~vga_in;
        game_p1_d     = game_acc & ~game_we;
        game_oor_p1_d = ~game_in;

        vga_rvalid_d  = vga_p1_q;
        vga_rdata_d   = vga_rdata_q;
        if (vga_p1_q) begin
            vga_rdata_d = vga_oor_p1_q ? '0 : mem_rdata;
        end
        game_rvalid_d = game_p1_q;
        game_rdata_d  = game_rdata_q;
        if (game_p1_q) begin
            game_rdata_d = game_oor_p1_q ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            clr_cnt_q     <= '0;
            clr_val_q     <= '0;
            vga_p1_q      <= 1'b0;
            vga_oor_p1_q  <= 1'b0;
            game_p1_q     <= 1'b0;
            game_oor_p1_q <= 1'b0;
            vga_rvalid_q  <= 1'b0;
            vga_rdata_q   <= '0;
            game_rvalid_q <= 1'b0;
            game_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            clr_val_q     <= clr_val_d;
            vga_p1_q      <= vga_p1_d;
            vga_oor_p1_q  <= vga_oor_p1_d;
            game_p1_q     <= game_p1_d;
            game_oor_p1_q <= game_oor_p1_d;
            vga_rvalid_q  <= vga_rvalid_d;
            vga_rdata_q   <= vga_rdata_d;
            game_rvalid_q <= game_rvalid_d;
            game_rdata_q  <= game_rdata_d;
        end
    end

endmodule

// File: tb/tb_grid_mem_arb.sv
// tb/tb_grid_mem_arb.sv - directed self-checking bench for grid_mem_arb with a behavioural grid RAM
module tb_grid_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vga_req;
    logic [7:0]  vga_gx;
    logic [6:0]  vga_gy;
    logic [1:0]  vga_rdata;
    logic        vga_rvalid;
    logic        game_valid;
    logic        game_ready;
    logic        game_we;
    logic [7:0]  game_gx;
    logic [6:0]  game_gy;
    logic [1:0]  game_wdata;
    logic [1:0]  game_rdata;
    logic        game_rvalid;
    logic        clr_start;
    logic [1:0]  clr_value;
    logic        clr_busy;
    logic        mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [1:0]  mem_wdata;
    logic [1:0]  mem_rdata = 2'b00;

    logic [1:0]  ram [0:8191];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    grid_mem_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_req    (vga_req),
        .vga_gx     (vga_gx),
        .vga_gy     (vga_gy),
        .vga_rdata  (vga_rdata),
        .vga_rvalid (vga_rvalid),
        .game_valid (game_valid),
        .game_ready (game_ready),
        .game_we    (game_we),
        .game_gx    (game_gx),
        .game_gy    (game_gy),
        .game_wdata (game_wdata),
        .game_rdata (game_rdata),
        .game_rvalid(game_rvalid),
        .clr_start  (clr_start),
        .clr_value  (clr_value),
        .clr_busy   (clr_busy),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic game_write(input logic [7:0] gx, input logic [6:0] gy, input logic [1:0] d,
                              input logic en_exp, input logic [12:0] a_exp, input string tag);
        @(negedge clk);
        game_valid = 1'b1; game_we = 1'b1; game_gx = gx; game_gy = gy; game_wdata = d;
        #1;
        chk({tag, "_ready"}, game_ready, 1);
        chk({tag, "_en"}, mem_en, en_exp);
        if (en_exp) begin
            chk({tag, "_we"}, mem_we, 1);
            chk({tag, "_addr"}, mem_addr, a_exp);
        end
        @(negedge clk);
        game_valid = 1'b0; game_we = 1'b0;
    endtask

    task automatic game_read(input logic [7:0] gx, input logic [6:0] gy, input logic [1:0] d_exp,
                             input logic en_exp, input string tag);
        @(negedge clk);
        game_valid = 1'b1; game_we = 1'b0; game_gx = gx; game_gy = gy;
        #1;
        chk({tag, "_ready"}, game_ready, 1);
        chk({tag, "_en"}, mem_en, en_exp);
        @(posedge clk); #1;
        chk({tag, "_rv_t1"}, game_rvalid, 0);
        @(negedge clk);
        game_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rv_t2"}, game_rvalid, 1);
        chk({tag, "_rdata"}, game_rdata, d_exp);
    endtask

    task automatic vga_read(input logic [7:0] gx, input logic [6:0] gy, input logic [1:0] d_exp,
                            input logic en_exp, input string tag);
        @(negedge clk);
        vga_req = 1'b1; vga_gx = gx; vga_gy = gy;
        #1;
        chk({tag, "_en"}, mem_en, en_exp);
        @(negedge clk);
        vga_req = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rv"}, vga_rvalid, 1);
        chk({tag, "_rdata"}, vga_rdata, d_exp);
    endtask

    // Runs one sweep from clr_start. With tog=1, vga_req is high on even busy cycles.
    // With stop_at>0, reset is asserted on the negedge where stop_at busy cycles have elapsed.
    task automatic sweep(input logic [1:0] val, input bit tog, input int stop_at,
                         output int n, output int nwr, output int nerr);
        n = 0; nwr = 0; nerr = 0;
        @(negedge clk);
        clr_start = 1'b1; clr_value = val;
        game_valid = 1'b1; game_we = 1'b0; game_gx = 8'd1; game_gy = 7'd1;
        #1;
        chk("sweep_start_ready", game_ready, 0);
        chk("sweep_start_busy", clr_busy, 0);
        for (int guard = 0; guard < 20000; guard++) begin
            @(negedge clk);
            clr_start = 1'b0; game_valid = 1'b0;
            if (stop_at > 0 && n == stop_at) begin
                rst_n = 1'b0;
                vga_req = 1'b0;
                return;
            end
            vga_req = tog && (n % 2 == 0);
            vga_gx = 8'd0; vga_gy = 7'd0;
            #1;
            if (!clr_busy) break;
            if (!vga_req) begin
                if (!(mem_en && mem_we && mem_addr == 13'(nwr) && mem_wdata == val)) nerr++;
                nwr++;
            end
            n++;
        end
        vga_req = 1'b0;
    endtask

    initial begin
        int n, nwr, nerr;
        rst_n = 1'b0; vga_req = 1'b0; vga_gx = '0; vga_gy = '0;
        game_valid = 1'b1; game_we = 1'b0; game_gx = 8'd3; game_gy = 7'd3; game_wdata = '0;
        clr_start = 1'b1; clr_value = 2'b11;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_ready", game_ready, 0);
            chk("rst_busy", clr_busy, 0);
            chk("rst_en", mem_en, 0);
            chk("rst_rvalids", {vga_rvalid, game_rvalid}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1; game_valid = 1'b0; clr_start = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", clr_busy, 0);

        game_write(8'd5, 7'd2, 2'b01, 1'b1, 13'd165, "gw_5_2");
        game_read(8'd5, 7'd2, 2'b01, 1'b1, "gr_5_2");
        @(posedge clk); #1;
        chk("gr_pulse_end", game_rvalid, 0);
        chk("gr_hold", game_rdata, 2'b01);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vga_req = (k < 4); vga_gx = 8'd5; vga_gy = 7'd2;
            game_valid = (k <= 4); game_we = 1'b0; game_gx = 8'd5; game_gy = 7'd2;
            #1;
            if (k <= 4) chk($sformatf("prio_ready_%0d", k), game_ready, (k == 4));
            @(posedge clk); #1;
            chk($sformatf("prio_vrv_%0d", k), vga_rvalid, (k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) chk($sformatf("prio_vrd_%0d", k), vga_rdata, 2'b01);
            chk($sformatf("prio_grv_%0d", k), game_rvalid, (k == 5));
        end
        @(negedge clk);
        vga_req = 1'b0; game_valid = 1'b0;

        game_write(8'd79, 7'd59, 2'b11, 1'b1, 13'd4799, "gw_last");
        game_read(8'd79, 7'd59, 2'b11, 1'b1, "gr_last_pre");

        sweep(2'b00, 1'b0, 0, n, nwr, nerr);
        chk("sweep0_cycles", n, 4800);
        chk("sweep0_writes", nwr, 4800);
        chk("sweep0_addr_err", nerr, 0);
        game_read(8'd79, 7'd59, 2'b00, 1'b1, "gr_last_clr0");

        sweep(2'b10, 1'b1, 0, n, nwr, nerr);
        chk("sweep_tog_cycles", n, 9600);
        chk("sweep_tog_writes", nwr, 4800);
        chk("sweep_tog_addr_err", nerr, 0);
        game_read(8'd79, 7'd59, 2'b10, 1'b1, "gr_last_clr2");

        game_read(8'd80, 7'd0, 2'b00, 1'b0, "gr_oor");
        game_write(8'd80, 7'd0, 2'b11, 1'b0, 13'd0, "gw_oor");
        game_read(8'd0, 7'd1, 2'b10, 1'b1, "gr_after_oor_wr");
        vga_read(8'd79, 7'd59, 2'b10, 1'b1, "vr_last");
        vga_read(8'd0, 7'd60, 2'b00, 1'b0, "vr_oor");

        sweep(2'b01, 1'b0, 1000, n, nwr, nerr);
        chk("midrst_writes", nwr, 1000);
        @(posedge clk); #1;
        chk("midrst_busy", clr_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(2'b11, 1'b0, 0, n, nwr, nerr);
        chk("restart_cycles", n, 4800);
        chk("restart_addr_err", nerr, 0);
        game_read(8'd79, 7'd59, 2'b11, 1'b1, "gr_last_clr3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
